// File: rtl/hi_lo_unit.sv
// ============================================================================
//  Module      : hi_lo_unit
//  Description : Architectural HI/LO register pair with multiply-accumulate
//                support (load / madd / msub), direct moves (mthi / mtlo)
//                and a 32-cycle restoring divider (signed and unsigned).
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    Clk     in   1   clock, all state updates on the rising edge
//    Reset   in   1   asynchronous active-high reset
//    Start   in   1   qualifies Op for one cycle (ignored while Busy/Reset)
//    Op      in   3   000 nop, 001 load, 010 madd, 011 msub,
//                     100 mthi, 101 mtlo, 110 div, 111 divu
//    ProdHi  in  32   upper half of the 64-bit multiplier product
//    ProdLo  in  32   lower half of the 64-bit multiplier product
//    A       in  32   move source / dividend
//    B       in  32   divisor
//    Hi      out 32   HI register
//    Lo      out 32   LO register
//    Busy    out  1   high while a division iterates
//    Done    out  1   one-cycle pulse when a division result is written
// ============================================================================
`default_nettype none

module hi_lo_unit (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [2:0]  Op,
  input  logic [31:0] ProdHi,
  input  logic [31:0] ProdLo,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] Hi,
  output logic [31:0] Lo,
  output logic        Busy,
  output logic        Done
);

  // --------------------------------------------------------------------------
  // Operation encodings
  // --------------------------------------------------------------------------
  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_MADD = 3'b010;
  localparam logic [2:0] OP_MSUB = 3'b011;
  localparam logic [2:0] OP_MTHI = 3'b100;
  localparam logic [2:0] OP_MTLO = 3'b101;
  localparam logic [2:0] OP_DIV  = 3'b110;
  localparam logic [2:0] OP_DIVU = 3'b111;

  localparam logic [5:0] LAST_ITER = 6'd31;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_DIV  = 1'b1
  } state_t;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t      state_q, state_d;
  logic [5:0]  cnt_q,   cnt_d;
  logic [31:0] hi_q,    hi_d;
  logic [31:0] lo_q,    lo_d;
  logic        done_q,  done_d;

  // Divider working registers
  logic [31:0] rem_q,   rem_d;    // partial remainder
  logic [31:0] quo_q,   quo_d;    // dividend bits shift out, quotient bits in
  logic [31:0] dvsr_q,  dvsr_d;   // divisor magnitude
  logic [31:0] dvnd_q,  dvnd_d;   // raw dividend, returned in HI on divide-by-zero
  logic        qneg_q,  qneg_d;   // quotient must be negated at the end
  logic        rneg_q,  rneg_d;   // remainder must be negated at the end

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic        w_accept;
  logic        w_is_signed;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [63:0] w_sum;
  logic [63:0] w_diff64;
  logic [32:0] w_shift;
  logic        w_ge;
  logic [31:0] w_sub;
  logic [31:0] w_rem_nx;
  logic [31:0] w_quo_nx;
  logic [31:0] w_rem_fix;
  logic [31:0] w_quo_fix;

  // Busy is the registered state itself, so new work is only taken in IDLE.
  assign w_accept    = Start && (state_q == S_IDLE);
  assign w_is_signed = (Op == OP_DIV);

  assign w_a_mag = (w_is_signed && A[31]) ? (32'd0 - A) : A;
  assign w_b_mag = (w_is_signed && B[31]) ? (32'd0 - B) : B;

  assign w_sum    = {hi_q, lo_q} + {ProdHi, ProdLo};
  assign w_diff64 = {hi_q, lo_q} - {ProdHi, ProdLo};

  // One restoring step: bring down the next dividend bit, try the subtract.
  // When the trial succeeds the true difference is below the divisor, so the
  // low 32 bits of a modular subtract are exact.
  assign w_shift  = {rem_q, quo_q[31]};
  assign w_ge     = (w_shift >= {1'b0, dvsr_q});
  assign w_sub    = w_shift[31:0] - dvsr_q;
  assign w_rem_nx = w_ge ? w_sub : w_shift[31:0];
  assign w_quo_nx = {quo_q[30:0], w_ge};

  // Sign fix-up: quotient truncates toward zero, remainder follows dividend.
  // 0x80000000 / -1 naturally wraps back to 0x80000000.
  assign w_quo_fix = qneg_q ? (32'd0 - w_quo_nx) : w_quo_nx;
  assign w_rem_fix = rneg_q ? (32'd0 - w_rem_nx) : w_rem_nx;

  // --------------------------------------------------------------------------
  // Next-state / datapath logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvsr_d  = dvsr_q;
    dvnd_d  = dvnd_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;

    case (state_q)
      S_IDLE: begin
        if (w_accept) begin
          case (Op)
            OP_NOP: begin
            end
            OP_LOAD: begin
              hi_d = ProdHi;
              lo_d = ProdLo;
            end
            OP_MADD: begin
              hi_d = w_sum[63:32];
              lo_d = w_sum[31:0];
            end
            OP_MSUB: begin
              hi_d = w_diff64[63:32];
              lo_d = w_diff64[31:0];
            end
            OP_MTHI: begin
              hi_d = A;
            end
            OP_MTLO: begin
              lo_d = A;
            end
            OP_DIV, OP_DIVU: begin
              state_d = S_DIV;
              cnt_d   = 6'd0;
              rem_d   = 32'd0;
              quo_d   = w_a_mag;
              dvsr_d  = w_b_mag;
              dvnd_d  = A;
              qneg_d  = w_is_signed && (A[31] ^ B[31]);
              rneg_d  = w_is_signed && A[31];
            end
            default: begin
            end
          endcase
        end
      end

      S_DIV: begin
        rem_d = w_rem_nx;
        quo_d = w_quo_nx;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == LAST_ITER) begin
          state_d = S_IDLE;
          cnt_d   = 6'd0;
          done_d  = 1'b1;
          if (dvsr_q == 32'd0) begin
            // Divide-by-zero result is fixed regardless of signedness.
            hi_d = dvnd_q;
            lo_d = 32'hFFFF_FFFF;
          end else begin
            hi_d = w_rem_fix;
            lo_d = w_quo_fix;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 6'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      done_q  <= 1'b0;
      rem_q   <= 32'd0;
      quo_q   <= 32'd0;
      dvsr_q  <= 32'd0;
      dvnd_q  <= 32'd0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvsr_q  <= dvsr_d;
      dvnd_q  <= dvnd_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs (all straight from registers)
  // --------------------------------------------------------------------------
  assign Hi   = hi_q;
  assign Lo   = lo_q;
  assign Busy = (state_q == S_DIV);
  assign Done = done_q;

endmodule

`default_nettype wire

// File: tb/tb_hi_lo_unit.sv
// ============================================================================
//  Module      : tb_hi_lo_unit
//  Description : Self-checking bench for hi_lo_unit. A vector table drives
//                every operation; expected HI/LO results go into a scoreboard
//                queue at issue time and are popped when the result appears.
//                Hand-written sequences cover async reset and aborting a
//                division.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hi_lo_unit;

  logic        Clk;
  logic        Reset;
  logic        Start;
  logic [2:0]  Op;
  logic [31:0] ProdHi;
  logic [31:0] ProdLo;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] Hi;
  logic [31:0] Lo;
  logic        Busy;
  logic        Done;

  hi_lo_unit dut (
    .Clk    (Clk),
    .Reset  (Reset),
    .Start  (Start),
    .Op     (Op),
    .ProdHi (ProdHi),
    .ProdLo (ProdLo),
    .A      (A),
    .B      (B),
    .Hi     (Hi),
    .Lo     (Lo),
    .Busy   (Busy),
    .Done   (Done)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  typedef struct {
    logic [2:0]  op;
    logic [31:0] ph;
    logic [31:0] pl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] eh;
    logic [31:0] el;
    bit          inj;   // fire an ignored mthi while the divider is busy
  } vec_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } res_t;

  localparam int NVEC = 16;

  vec_t        vecs [NVEC];
  res_t        sb [$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge where the result is visible.
  // For divisions that is the Done cycle, so the next call issues back-to-back.
  task automatic run_op(input vec_t v, input string nm);
    res_t r;
    int   busy_n;
    bit   hold_bad;
    Start  = 1'b1;
    Op     = v.op;
    ProdHi = v.ph;
    ProdLo = v.pl;
    A      = v.a;
    B      = v.b;
    sb.push_back('{hi: v.eh, lo: v.el});
    @(negedge Clk);
    Start  = 1'b0;
    Op     = 3'b000;
    A      = 32'hA5A5_A5A5;   // operands must already be latched
    B      = 32'h5A5A_5A5A;
    ProdHi = 32'h0;
    ProdLo = 32'h0;
    busy_n   = 0;
    hold_bad = 1'b0;
    if (v.op[2:1] == 2'b11) begin
      for (int i = 0; i < 40 && Busy === 1'b1; i++) begin
        busy_n++;
        if (Hi !== m_hi || Lo !== m_lo || Done !== 1'b0) hold_bad = 1'b1;
        if (v.inj && busy_n == 5) begin
          Start = 1'b1;
          Op    = 3'b100;
          A     = 32'hCAFE_BABE;
        end
        @(negedge Clk);
        Start = 1'b0;
        Op    = 3'b000;
      end
      chk({nm, " busy_cycles"}, 32'(busy_n), 32'd32);
      chk({nm, " hold"}, {31'b0, hold_bad}, 32'd0);
      chk({nm, " done"}, {31'b0, Done}, 32'd1);
    end else begin
      chk({nm, " busy_done"}, {30'b0, Busy, Done}, 32'd0);
    end
    if (sb.size() == 0) begin
      chk({nm, " sb_empty"}, 32'd1, 32'd0);
    end else begin
      r = sb.pop_front();
      chk({nm, " hi"}, Hi, r.hi);
      chk({nm, " lo"}, Lo, r.lo);
      m_hi = r.hi;
      m_lo = r.lo;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit bad;
    Reset  = 1'b0;
    Start  = 1'b0;
    Op     = 3'b000;
    ProdHi = 32'h0;
    ProdLo = 32'h0;
    A      = 32'h0;
    B      = 32'h0;

    //         op      ProdHi        ProdLo        A             B             expHi         expLo         inj
    vecs[0]  = '{3'b001, 32'h00000001, 32'hFFFFFFFF, 32'h0,        32'h0,        32'h00000001, 32'hFFFFFFFF, 1'b0};
    vecs[1]  = '{3'b010, 32'h00000001, 32'hFFFFFFFF, 32'h0,        32'h0,        32'h00000003, 32'hFFFFFFFE, 1'b0};
    vecs[2]  = '{3'b001, 32'h00000000, 32'h00000000, 32'h0,        32'h0,        32'h00000000, 32'h00000000, 1'b0};
    vecs[3]  = '{3'b011, 32'h00000000, 32'h00000001, 32'h0,        32'h0,        32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0};
    vecs[4]  = '{3'b100, 32'h11111111, 32'h22222222, 32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 32'hFFFFFFFF, 1'b0};
    vecs[5]  = '{3'b101, 32'h11111111, 32'h22222222, 32'h00012345, 32'h0,        32'hDEADBEEF, 32'h00012345, 1'b0};
    vecs[6]  = '{3'b000, 32'h33333333, 32'h44444444, 32'h55555555, 32'h0,        32'hDEADBEEF, 32'h00012345, 1'b0};
    vecs[7]  = '{3'b110, 32'h0,        32'h0,        32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[8]  = '{3'b111, 32'h0,        32'h0,        32'hFFFFFFF9, 32'h00000002, 32'h00000001, 32'h7FFFFFFC, 1'b0};
    vecs[9]  = '{3'b110, 32'h0,        32'h0,        32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vecs[10] = '{3'b110, 32'h0,        32'h0,        32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
    vecs[11] = '{3'b110, 32'h0,        32'h0,        32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 1'b0};
    vecs[12] = '{3'b111, 32'h0,        32'h0,        32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF, 1'b1};
    vecs[13] = '{3'b110, 32'h0,        32'h0,        32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF, 1'b0};
    vecs[14] = '{3'b010, 32'h00000000, 32'h00000005, 32'h0,        32'h0,        32'hFFFFFFFC, 32'h00000004, 1'b0};
    vecs[15] = '{3'b110, 32'h0,        32'h0,        32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'h00000002, 1'b0};

    // Asynchronous reset, checked before any clock edge.
    #1 Reset = 1'b1;
    #1;
    chk("reset hi", Hi, 32'h0);
    chk("reset lo", Lo, 32'h0);
    chk("reset busy_done", {30'b0, Busy, Done}, 32'd0);
    #1 Reset = 1'b0;
    m_hi = 32'h0;
    m_lo = 32'h0;

    @(negedge Clk);
    for (int i = 0; i < NVEC; i++) begin
      run_op(vecs[i], $sformatf("vec%0d", i));
    end

    // Abort a signed division with reset partway through.
    @(negedge Clk);
    chk("pre_abort done_low", {31'b0, Done}, 32'd0);
    Start = 1'b1;
    Op    = 3'b110;
    A     = 32'hFFFFFFF9;
    B     = 32'h00000002;
    @(negedge Clk);
    Start = 1'b0;
    Op    = 3'b000;
    for (int i = 0; i < 9; i++) @(negedge Clk);
    chk("abort busy_before", {31'b0, Busy}, 32'd1);
    #2 Reset = 1'b1;
    #1;
    chk("abort hi", Hi, 32'h0);
    chk("abort lo", Lo, 32'h0);
    chk("abort busy_done", {30'b0, Busy, Done}, 32'd0);
    m_hi = 32'h0;
    m_lo = 32'h0;
    // Start during reset must be ignored.
    Start = 1'b1;
    Op    = 3'b101;
    A     = 32'h00000009;
    @(posedge Clk);
    #1;
    chk("start_in_reset lo", Lo, 32'h0);
    @(negedge Clk);
    Start = 1'b0;
    Op    = 3'b000;
    Reset = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge Clk);
      if (Done !== 1'b0 || Busy !== 1'b0 || Hi !== 32'h0 || Lo !== 32'h0) bad = 1'b1;
    end
    chk("abort quiet", {31'b0, bad}, 32'd0);
    run_op('{3'b101, 32'h0, 32'h0, 32'h00000005, 32'h0, 32'h00000000, 32'h00000005, 1'b0}, "post_abort mtlo");

    chk("sb drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/hi_lo_unit.md
HI_LO_UNIT -- requirements
Module: hi_lo_unit

Interface
REQ-001 The block SHALL have port Clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-002 The block SHALL have port Reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 The block SHALL have port Start, input, 1 bit: qualifies Op for one cycle.
REQ-004 The block SHALL have port Op, input, 3 bits, with these encodings:
- 000 nop
- 001 load product
- 010 madd
- 011 msub
- 100 mthi
- 101 mtlo
- 110 div (signed)
- 111 divu
REQ-005 The block SHALL have ports ProdHi and ProdLo, input, 32 bits each: the 64-bit product {ProdHi,ProdLo} from the ALU multiply.
REQ-006 The block SHALL have ports A and B, input, 32 bits each: A is the move source and the dividend; B is the divisor.
REQ-007 The block SHALL have ports Hi and Lo, output, 32 bits each: architectural HI/LO register contents.
REQ-008 The block SHALL have port Busy, output, 1 bit: high while a division iterates.
REQ-009 The block SHALL have port Done, output, 1 bit: one-cycle pulse when a division result is written.

Function
REQ-010 The block SHALL accept an operation only on a rising edge where Start=1 and Busy=0; Start while Busy=1 SHALL be ignored with no state change.
REQ-011 Ops 001-101 SHALL complete at the accepting edge, with Hi/Lo visible the following cycle, Busy staying 0 and Done staying 0.
REQ-012 Op 001 SHALL set Hi=ProdHi and Lo=ProdLo.
REQ-013 Op 010 SHALL set {Hi,Lo} = {Hi,Lo} + {ProdHi,ProdLo} modulo 2^64, with no saturation.
REQ-014 Op 011 SHALL set {Hi,Lo} = {Hi,Lo} - {ProdHi,ProdLo} modulo 2^64.
REQ-015 Op 100 SHALL set Hi=A with Lo unchanged; op 101 SHALL set Lo=A with Hi unchanged; op 000 SHALL change nothing.
REQ-016 Division SHALL use a two-state FSM:
- IDLE -> DIV on an accepted op 110/111, latching A, B and the signedness.
- DIV -> IDLE after exactly 32 iteration cycles.
REQ-017 In DIV, the block SHALL perform one restoring (shift-subtract) quotient bit per cycle on operand magnitudes, using a 6-bit iteration counter.
REQ-018 Busy SHALL be 1 for exactly the 32 cycles following the accepting edge; at the 32nd iteration edge the block SHALL write Hi=remainder and Lo=quotient, set Busy=0, and set Done=1 for one cycle.
REQ-019 During DIV, Hi and Lo SHALL hold their pre-division values until the write edge.
REQ-020 For signed division, the quotient SHALL truncate toward zero and the remainder SHALL take the sign of the dividend.
REQ-021 For signed division, 0x80000000 / 0xFFFFFFFF SHALL yield Lo=0x80000000 and Hi=0.
REQ-022 For unsigned division, operands SHALL be treated as 32-bit unsigned.
REQ-023 For a zero divisor, both div and divu SHALL take the full 32-cycle latency and yield Lo=0xFFFFFFFF and Hi=A.
REQ-024 A new Start SHALL be accepted on the same edge where Done is asserted only if Busy=0 at that edge; the first legal start is therefore the cycle in which Done=1.
REQ-025 Outputs SHALL be registered; Hi and Lo SHALL have no combinational path from the inputs.

Reset
REQ-026 Reset=1 SHALL immediately, without waiting for Clk, force Hi=0, Lo=0, Busy=0, Done=0, FSM=IDLE, counter=0 and divider working registers to 0.
REQ-027 Reset asserted mid-division SHALL abort the division with no partial result written; after release the block SHALL be IDLE and accept Start on the next edge.
REQ-028 While Reset=1, Start SHALL be ignored.

Verification
REQ-029 The bench SHALL check: Reset pulse -> Hi=0, Lo=0, Busy=0, Done=0 before any clock edge.
REQ-030 The bench SHALL check: op 001 with ProdHi=0x00000001, ProdLo=0xFFFFFFFF, then op 010 with the same product -> Hi=0x00000003, Lo=0xFFFFFFFE (carry across the halves).
REQ-031 The bench SHALL check: Hi=0, Lo=0, then op 011 with product 0x00000000_00000001 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFFF.
REQ-032 The bench SHALL check: op 110 with A=-7 (0xFFFFFFF9), B=2 -> Busy high for 32 cycles, Hi/Lo unchanged meanwhile, then Lo=0xFFFFFFFD (-3), Hi=0xFFFFFFFF (-1), Done high for one cycle; op 111 with the same operands -> Lo=0x7FFFFFFC, Hi=1.
REQ-033 The bench SHALL check: op 111 with A=0x12345678, B=0 -> after 32 cycles Lo=0xFFFFFFFF, Hi=0x12345678; Start op 100 asserted while Busy is ignored.
REQ-034 The bench SHALL check: op 110 started, Reset asserted at iteration 10 -> Busy=0 and Hi=Lo=0 immediately, Done never pulses, and a subsequent op 101 with A=5 gives Lo=5.
